// File: rtl/regdump_streamer.sv
// regdump_streamer: walks reg_sel over the CPU register file and streams each sampled word with its index.
// Define REGDUMP_CHKSUM_EN to append an XOR checksum word (index all-ones) after the last register.
module regdump_streamer #(
  parameter int NUM_REGS = 32,
  parameter int SEL_W    = 5,
  parameter int READ_LAT = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [SEL_W-1:0] reg_sel,
  input  logic [31:0]      reg_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [SEL_W-1:0] out_idx,
  output logic             out_last
);
  typedef enum logic [1:0] {IDLE, SETTLE, SEND} state_t;
  localparam int CNT_W = $clog2(READ_LAT + 2);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0] LAT = CNT_W'(READ_LAT);
  state_t state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d, sel_q, sel_d, oidx_q, oidx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic busy_q, busy_d, done_q, done_d, vld_q, vld_d, last_q, last_d;
`ifdef REGDUMP_CHKSUM_EN
  logic [31:0] chk_q, chk_d;
  logic tail_q, tail_d;
`endif
  wire hs = vld_q & out_ready;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sel_q   <= '0;
      oidx_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
`ifdef REGDUMP_CHKSUM_EN
      chk_q   <= '0;
      tail_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      oidx_q  <= oidx_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
`ifdef REGDUMP_CHKSUM_EN
      chk_q   <= chk_d;
      tail_q  <= tail_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    oidx_d  = oidx_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    vld_d   = vld_q;
    last_d  = last_q;
`ifdef REGDUMP_CHKSUM_EN
    chk_d   = chk_q;
    tail_d  = tail_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d = SETTLE;
        busy_d  = 1'b1;
        idx_d   = '0;
        sel_d   = '0;
        cnt_d   = LAT;
`ifdef REGDUMP_CHKSUM_EN
        chk_d   = '0;
`endif
      end
      SETTLE: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      else begin
        state_d = SEND;
        vld_d   = 1'b1;
        data_d  = reg_data;
        oidx_d  = idx_q;
`ifdef REGDUMP_CHKSUM_EN
        last_d  = 1'b0;
        tail_d  = idx_q == LAST_IDX;
        chk_d   = chk_q ^ reg_data;
`else
        last_d  = idx_q == LAST_IDX;
`endif
      end
      SEND: if (hs) begin
        vld_d = 1'b0;
        if (last_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          sel_d   = '0;
          last_d  = 1'b0;
        end
`ifdef REGDUMP_CHKSUM_EN
        else if (tail_q) begin
          // Checksum word follows immediately; reg_sel is no longer meaningful here.
          vld_d  = 1'b1;
          data_d = chk_q;
          oidx_d = '1;
          last_d = 1'b1;
          tail_d = 1'b0;
        end
`endif
        else begin
          state_d = SETTLE;
          idx_d   = idx_q + 1'b1;
          sel_d   = idx_q + 1'b1;
          cnt_d   = LAT;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign busy      = busy_q;
  assign done      = done_q;
  assign reg_sel   = sel_q;
  assign out_valid = vld_q;
  assign out_data  = data_q;
  assign out_idx   = oidx_q;
  assign out_last  = last_q;
endmodule

// File: doc/regdump_streamer.md
Name: regdump_streamer

Overview:
- Hardware initiator for the CPU register-file debug read port (reg_sel out, reg_data in).
- On a start pulse it walks reg_sel over registers 0..NUM_REGS-1 and samples each reg_data value.
- Each sampled word goes out on a valid/ready stream tagged with its register index.
- Sits beside pipeline_sccomp and replaces bench-driven reg_sel scanning for board-level dumps (UART or trace FIFO downstream).

Parameters:
- NUM_REGS, 32, number of registers scanned, indices 0..NUM_REGS-1; legal range 1..2^SEL_W.
- SEL_W, 5, width of reg_sel and out_idx.
- READ_LAT, 0, extra settle cycles between a reg_sel change and reg_data sampling; 0 = async RF read.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle request to begin a dump; ignored while busy.
- busy  out  1  dump in progress.
- done  out  1  one-cycle pulse after the final word handshakes.
- reg_sel  out  SEL_W  register select driven to the CPU debug port.
- reg_data  in  32  register value returned by the CPU for reg_sel.
- out_valid  out  1  stream word valid.
- out_ready  in  1  downstream ready.
- out_data  out  32  captured register value.
- out_idx  out  SEL_W  register index of out_data.
- out_last  out  1  marks the final word of a dump.

Behaviour:
- Reset (rstn=0 at an edge) forces all outputs to 0: busy, done, reg_sel, out_valid, out_data, out_idx, out_last. FSM goes to IDLE and counters clear. Reset mid-dump aborts with no done pulse.
- FSM states are IDLE, SETTLE, SEND.
- IDLE: reg_sel=0, busy=0. start=1 at edge E moves to SETTLE with idx=0, reg_sel=0, settle counter=READ_LAT, and busy=1 from E.
- SETTLE: counter decrements each edge while nonzero. At the edge where the counter is 0:
  - out_data<=reg_data, out_idx<=idx, out_valid<=1, out_last<=(idx==NUM_REGS-1).
  - State moves to SEND.
  - Net effect: reg_data is sampled at E+READ_LAT+1, and out_valid rises at that edge.
- SEND: out_data, out_idx and out_last are held stable while out_valid=1 and out_ready=0. There is no timeout.
- Handshake is out_valid&out_ready at edge H, and always clears out_valid at H.
  - If not last: idx<=idx+1, reg_sel<=idx+1, counter<=READ_LAT, state to SETTLE.
  - If last: state to IDLE, busy<=0, done<=1 for exactly one cycle, reg_sel<=0, out_last<=0.
- Throughput with out_ready tied high is READ_LAT+2 cycles per register; NUM_REGS=32, READ_LAT=0 gives 64 cycles from start to done.
- start while busy=1 has no effect. start in the same cycle done is high is accepted, since the FSM is already in IDLE.
- idx never wraps: the scan ends at NUM_REGS-1. The SEL_W arithmetic must not overflow when NUM_REGS=2^SEL_W; use the last flag, not idx+1 compare.
- reg_sel changes only at a start edge or a handshake edge, so it is stable for the whole SETTLE/SEND window.

Optional Feature:
- Macro REGDUMP_CHKSUM_EN.
- Defined:
  - An XOR accumulator, cleared at start, folds in each captured word.
  - After the register at NUM_REGS-1 handshakes (with out_last=0 on it), one extra word is emitted: out_data=accumulator, out_idx=all-ones, out_last=1.
  - done pulses after that word handshakes.
  - Latency grows by one handshake cycle: 65 cycles for 32 regs, READ_LAT=0, ready high.
- Undefined: no accumulator; out_last is on register NUM_REGS-1, as described above.

Test Plan:
- Preload rN=N*0x11, ready=1, READ_LAT=0, start at cycle 0 -> 32 words idx 0..31 with data N*0x11, out_last only on idx 31, done pulses once, 64 cycles start-to-done.
- out_ready toggled 1-in-3, and held low 10 cycles on idx 5 -> out_data and out_idx stable during stall, no word lost or duplicated, order 0..31.
- READ_LAT=2, RF model returning data 2 cycles after reg_sel change -> every captured word correct, 4 cycles per register with ready high.
- start re-pulsed at cycles 3 and 20 during a dump -> ignored, exactly one done; start in the done cycle -> second dump begins immediately.
- rstn=0 for one edge while in SEND at idx 7 -> all outputs 0 next cycle, no done; fresh start restarts at idx 0.
- REGDUMP_CHKSUM_EN defined, rN=N -> 33rd word out_data=XOR(0..31)=0x00000000, out_idx=5'h1F, out_last=1; then with r3=0xFF -> checksum 0x000000FC.
